// File: rtl/lfsr_byte_checker_if.sv
// Byte stream and status bundle between a stream source/monitor and lfsr_byte_checker.
// The master drives the stream and control inputs; the slave (the checker) drives status.
interface lfsr_byte_checker_if #(
   parameter int CNT_W = 16
);
   logic             en;
   logic             din_valid;
   logic [7:0]       din;
   logic             clr_cnt;
   logic             locked;
   logic             err_pulse;
   logic [3:0]       err_bits;
   logic [CNT_W-1:0] err_cnt;
   logic [CNT_W-1:0] chk_cnt;

   modport master (
      output en, din_valid, din, clr_cnt,
      input  locked, err_pulse, err_bits, err_cnt, chk_cnt
   );

   modport slave (
      input  en, din_valid, din, clr_cnt,
      output locked, err_pulse, err_bits, err_cnt, chk_cnt
   );
endinterface

// File: rtl/lfsr_byte_checker.sv
// Receive-side checker for byte-wide 32-bit XNOR LFSR streams.
// Self-seeds from four received bytes, verifies a run of predicted bytes,
// then free-runs its own prediction while counting bytes and bit errors.
module lfsr_byte_checker #(
   parameter int GOOD_THRESH = 4,
   parameter int LOSS_THRESH = 3,
   parameter int CNT_W       = 16
) (
   input logic               clk,
   input logic               rst_n,
   lfsr_byte_checker_if.slave bus
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] LOAD   = 2'd1;
   localparam logic [1:0] VERIFY = 2'd2;
   localparam logic [1:0] LOCKED = 2'd3;

   // Run counters compare against the last count before the threshold is reached.
   localparam logic [3:0] GOOD_LAST = 4'(GOOD_THRESH - 1);
   localparam logic [3:0] LOSS_LAST = 4'(LOSS_THRESH - 1);

   logic [1:0]       state;
   logic [31:0]      s;
   logic [1:0]       ld_cnt;
   logic [3:0]       good_run;
   logic [3:0]       bad_run;
   logic             err_pulse;
   logic [3:0]       err_bits;
   logic [CNT_W-1:0] err_cnt;
   logic [CNT_W-1:0] chk_cnt;

   logic [31:0]      pred_s;
   logic [31:0]      load_s;
   logic [7:0]       mism;
   logic [3:0]       mism_bits;
   logic             lock_acc;
   logic [CNT_W:0]   err_sum;

   // Eight XNOR steps from the current state; the low byte is the expected byte.
   // NOTE: every variable assigned in an always_comb gets a value before any
   // conditional or loop, otherwise synthesis infers a latch.
   always_comb begin
      pred_s = s;
      for (int i = 0; i < 8; i++) begin
         pred_s = {pred_s[30:0], ~(pred_s[31] ^ pred_s[21] ^ pred_s[1] ^ pred_s[0])};
      end
   end

   assign load_s = {s[23:0], bus.din};
   assign mism   = bus.din ^ pred_s[7:0];

   // Population count of the mismatch between received and expected byte.
   always_comb begin
      mism_bits = 4'd0;
      for (int i = 0; i < 8; i++) begin
         mism_bits = mism_bits + 4'(mism[i]);
      end
   end

   assign lock_acc = bus.en && bus.din_valid && (state == LOCKED);
   assign err_sum  = {1'b0, err_cnt} + {{(CNT_W - 3){1'b0}}, mism_bits};

   // Sync FSM: seed load, verification run, locked tracking with loss detection.
   // NOTE: state registers use non-blocking assignments so every register in
   // this block samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         s         <= 32'd0;
         ld_cnt    <= 2'd0;
         good_run  <= 4'd0;
         bad_run   <= 4'd0;
         err_pulse <= 1'b0;
         err_bits  <= 4'd0;
      end else begin
         err_pulse <= 1'b0;
         if (!bus.en) begin
            state <= IDLE;
         end else begin
            case (state)
               IDLE: begin
                  state  <= LOAD;
                  ld_cnt <= 2'd0;
               end
               LOAD: if (bus.din_valid) begin
                  s <= load_s;
                  if (ld_cnt == 2'd3) begin
                     ld_cnt <= 2'd0;
                     // All-ones is the XNOR lockup state; keep loading instead.
                     if (load_s != 32'hFFFF_FFFF) begin
                        state    <= VERIFY;
                        good_run <= 4'd0;
                     end
                  end else begin
                     ld_cnt <= ld_cnt + 2'd1;
                  end
               end
               VERIFY: if (bus.din_valid) begin
                  s <= pred_s;
                  if (mism != 8'd0) begin
                     state  <= LOAD;
                     ld_cnt <= 2'd0;
                  end else if (good_run == GOOD_LAST) begin
                     state   <= LOCKED;
                     bad_run <= 4'd0;
                  end else begin
                     good_run <= good_run + 4'd1;
                  end
               end
               LOCKED: if (bus.din_valid) begin
                  // Free-run on the prediction; received data never reseeds here.
                  s        <= pred_s;
                  err_bits <= mism_bits;
                  if (mism != 8'd0) begin
                     err_pulse <= 1'b1;
                     if (bad_run == LOSS_LAST) begin
                        state  <= LOAD;
                        ld_cnt <= 2'd0;
                     end else begin
                        bad_run <= bad_run + 4'd1;
                     end
                  end else begin
                     bad_run <= 4'd0;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   // Saturating byte and bit-error counters; a clear wins over that cycle's increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chk_cnt <= '0;
         err_cnt <= '0;
      end else if (bus.clr_cnt) begin
         chk_cnt <= '0;
         err_cnt <= '0;
      end else if (lock_acc) begin
         if (chk_cnt != '1) chk_cnt <= chk_cnt + CNT_W'(1);
         err_cnt <= err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
      end
   end

   assign bus.locked    = (state == LOCKED);
   assign bus.err_pulse = err_pulse;
   assign bus.err_bits  = err_bits;
   assign bus.err_cnt   = err_cnt;
   assign bus.chk_cnt   = chk_cnt;

endmodule

// File: tb/tb_lfsr_byte_checker.sv
// Scoreboard bench for lfsr_byte_checker: a driver issues bytes and pushes the
// reference model's expected status; a monitor pops and compares after each edge.
module tb_lfsr_byte_checker;

   localparam int GOOD_THRESH = 4;
   localparam int LOSS_THRESH = 3;
   localparam int CNT_W       = 4;
   localparam int CMAX        = (1 << CNT_W) - 1;

   typedef enum {M_IDLE, M_LOAD, M_VERIFY, M_LOCKED} mode_t;

   typedef struct {
      logic       locked;
      logic       err_pulse;
      logic [3:0] err_bits;
      int         err_cnt;
      int         chk_cnt;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;

   lfsr_byte_checker_if #(.CNT_W(CNT_W)) bus ();

   lfsr_byte_checker #(
      .GOOD_THRESH(GOOD_THRESH),
      .LOSS_THRESH(LOSS_THRESH),
      .CNT_W      (CNT_W)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   exp_t exp_q[$];

   // Reference model state.
   mode_t       m_mode;
   logic [7:0]  m_seed[$];
   logic [31:0] m_s;
   int          m_good, m_bad, m_chk, m_err, m_bits;
   logic        m_pulse;

   // Source generator state.
   logic [31:0] g_s;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Next byte of the stream from a generator state; first produced bit lands in bit 7.
   function automatic logic [7:0] gen_next(inout logic [31:0] st);
      logic [7:0] r = 8'd0;
      logic       nb;
      for (int i = 0; i < 8; i++) begin
         nb = ~(st[31] ^ st[21] ^ st[1] ^ st[0]);
         st = {st[30:0], nb};
         r  = {r[6:0], nb};
      end
      return r;
   endfunction

   function automatic int sat_add(input int a, input int b);
      return (a + b > CMAX) ? CMAX : a + b;
   endfunction

   function automatic void model_reset();
      m_mode = M_IDLE;
      m_seed.delete();
      m_s = 32'd0;
      m_good = 0; m_bad = 0; m_chk = 0; m_err = 0; m_bits = 0;
      m_pulse = 1'b0;
   endfunction

   // One clock of checker behaviour, expressed in terms of the stream rules.
   function automatic void model_step(input logic e, input logic v, input logic [7:0] d, input logic c);
      logic [7:0] p;
      int         pc;
      m_pulse = 1'b0;
      if (!e) begin
         m_mode = M_IDLE;
      end else begin
         case (m_mode)
            M_IDLE: begin
               m_mode = M_LOAD;
               m_seed.delete();
            end
            M_LOAD: if (v) begin
               m_seed.push_back(d);
               if (m_seed.size() == 4) begin
                  m_s = {m_seed[0], m_seed[1], m_seed[2], m_seed[3]};
                  m_seed.delete();
                  if (m_s != 32'hFFFF_FFFF) begin
                     m_mode = M_VERIFY;
                     m_good = 0;
                  end
               end
            end
            M_VERIFY: if (v) begin
               p = gen_next(m_s);
               if (p != d) begin
                  m_mode = M_LOAD;
                  m_seed.delete();
               end else begin
                  m_good++;
                  if (m_good == GOOD_THRESH) begin
                     m_mode = M_LOCKED;
                     m_bad  = 0;
                  end
               end
            end
            M_LOCKED: if (v) begin
               p      = gen_next(m_s);
               pc     = $countones(p ^ d);
               m_bits = pc;
               m_chk  = sat_add(m_chk, 1);
               m_err  = sat_add(m_err, pc);
               if (pc != 0) begin
                  m_pulse = 1'b1;
                  m_bad++;
                  if (m_bad == LOSS_THRESH) begin
                     m_mode = M_LOAD;
                     m_seed.delete();
                  end
               end else begin
                  m_bad = 0;
               end
            end
         endcase
      end
      if (c) begin
         m_chk = 0;
         m_err = 0;
      end
   endfunction

   task automatic drive(input logic e, input logic v, input logic [7:0] d, input logic c);
      exp_t x;
      @(negedge clk);
      bus.en        = e;
      bus.din_valid = v;
      bus.din       = d;
      bus.clr_cnt   = c;
      model_step(e, v, d, c);
      x.locked    = (m_mode == M_LOCKED);
      x.err_pulse = m_pulse;
      x.err_bits  = 4'(m_bits);
      x.err_cnt   = m_err;
      x.chk_cnt   = m_chk;
      exp_q.push_back(x);
   endtask

   // Send one byte, sometimes preceded by an idle gap.
   task automatic send(input logic [7:0] d, input logic c);
      if ($urandom_range(0, 3) == 0) drive(1'b1, 1'b0, 8'($urandom), 1'b0);
      drive(1'b1, 1'b1, d, c);
   endtask

   task automatic send_seed(input logic [31:0] seed);
      send(seed[31:24], 1'b0);
      send(seed[23:16], 1'b0);
      send(seed[15:8], 1'b0);
      send(seed[7:0], 1'b0);
      g_s = seed;
   endtask

   task automatic send_good(input int n);
      for (int i = 0; i < n; i++) send(gen_next(g_s), 1'b0);
   endtask

   // Wait until the last driven byte has been taken by an edge.
   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   // Monitor: one expected status per driven cycle, compared just after the edge.
   initial begin
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            check("locked",    int'(bus.locked),    int'(x.locked));
            check("err_pulse", int'(bus.err_pulse), int'(x.err_pulse));
            check("err_bits",  int'(bus.err_bits),  int'(x.err_bits));
            check("err_cnt",   int'(bus.err_cnt),   x.err_cnt);
            check("chk_cnt",   int'(bus.chk_cnt),   x.chk_cnt);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  e8;
      logic [31:0] seed;
      int          held_chk, held_err;

      rst_n = 1'b0;
      bus.en = 1'b0; bus.din_valid = 1'b0; bus.din = 8'd0; bus.clr_cnt = 1'b0;
      model_reset();
      #12;
      check("rst_locked",  int'(bus.locked),    0);
      check("rst_pulse",   int'(bus.err_pulse), 0);
      check("rst_err_cnt", int'(bus.err_cnt),   0);
      check("rst_chk_cnt", int'(bus.chk_cnt),   0);
      @(negedge clk);
      rst_n = 1'b1;

      // Seed sync from an all-zero seed.
      drive(1'b1, 1'b0, 8'd0, 1'b0);
      g_s = 32'd0;
      send_seed(32'd0);
      send_good(3);
      settle();
      check("seed_not_yet_locked", int'(bus.locked), 0);
      send_good(1);
      settle();
      check("seed_locked", int'(bus.locked), 1);
      check("seed_err_cnt", int'(bus.err_cnt), 0);
      send_good(2);

      // Error injection on bits 0 and 5 with cleared counters.
      drive(1'b1, 1'b0, 8'd0, 1'b1);
      send(gen_next(g_s) ^ 8'h21, 1'b0);
      settle();
      check("inj_pulse",  int'(bus.err_pulse), 1);
      check("inj_bits",   int'(bus.err_bits),  2);
      check("inj_cnt",    int'(bus.err_cnt),   2);
      check("inj_locked", int'(bus.locked),    1);
      send_good(1);
      settle();
      check("inj_next_bits", int'(bus.err_bits), 0);

      // Saturation, then clear coinciding with a single-bit error.
      drive(1'b1, 1'b0, 8'd0, 1'b1);
      send_good(20);
      settle();
      check("sat_chk", int'(bus.chk_cnt), CMAX);
      send(gen_next(g_s) ^ 8'h04, 1'b1);
      settle();
      check("clr_chk",   int'(bus.chk_cnt),   0);
      check("clr_err",   int'(bus.err_cnt),   0);
      check("clr_pulse", int'(bus.err_pulse), 1);
      send_good(2);

      // Loss of sync: three 0x00 bytes against nonzero predictions.
      drive(1'b1, 1'b0, 8'd0, 1'b1);
      for (int i = 0; i < LOSS_THRESH; i++) begin
         e8 = gen_next(g_s);
         send((e8 == 8'h00) ? 8'hFF : 8'h00, 1'b0);
      end
      settle();
      check("loss_locked", int'(bus.locked), 0);

      // Lockup seed is rejected, then a valid seed locks after 4+4 bytes.
      send_seed(32'hFFFF_FFFF);
      seed = 32'h1234_5678;
      send_seed(seed);
      send_good(GOOD_THRESH);
      settle();
      check("relock_after_lockup", int'(bus.locked), 1);

      // Randomised stream: random seeds, gaps, bit errors and clears.
      for (int it = 0; it < 300; it++) begin
         if (m_mode == M_LOAD) begin
            send_seed($urandom);
         end else begin
            e8 = gen_next(g_s);
            if ($urandom_range(0, 7) == 0) e8 = e8 ^ 8'($urandom_range(1, 255));
            send(e8, ($urandom_range(0, 19) == 0));
         end
      end

      // Dropping en leaves IDLE next cycle with counters held.
      while (m_mode != M_LOCKED) begin
         if (m_mode == M_LOAD) send_seed($urandom);
         else send_good(1);
      end
      held_chk = m_chk;
      held_err = m_err;
      drive(1'b0, 1'b1, gen_next(g_s), 1'b0);
      settle();
      check("en_low_locked", int'(bus.locked),  0);
      check("en_low_chk",    int'(bus.chk_cnt), held_chk);
      check("en_low_err",    int'(bus.err_cnt), held_err);

      // Re-enable, relock, then async reset mid-LOCKED.
      drive(1'b1, 1'b0, 8'd0, 1'b0);
      send_seed(32'hA5C3_0F96);
      send_good(GOOD_THRESH + 3);
      settle();
      check("pre_reset_locked", int'(bus.locked), 1);
      rst_n = 1'b0;
      #1;
      model_reset();
      check("async_locked",   int'(bus.locked),    0);
      check("async_pulse",    int'(bus.err_pulse), 0);
      check("async_bits",     int'(bus.err_bits),  0);
      check("async_err_cnt",  int'(bus.err_cnt),   0);
      check("async_chk_cnt",  int'(bus.chk_cnt),   0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 1'b0, 8'd0, 1'b0);
      send_seed(32'h0BAD_F00D);
      send_good(GOOD_THRESH + 5);
      settle();
      check("post_reset_locked", int'(bus.locked), 1);

      @(posedge clk);
      #3;
      check("queue_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
